// File: rtl/req_dispatch_pkg.sv
// Shared types and helpers for the request dispatcher.
package req_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        POP   = 2'd2
    } dispatch_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: lowest set bit at or above ptr,
// falling back to the lowest set bit overall.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    pending_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] sel_o,
    output logic [N-1:0]    onehot_o,
    output logic            any_o
);

    logic [IdxW-1:0] hi_sel;
    logic [IdxW-1:0] lo_sel;
    logic            hi_found;

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        hi_sel   = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                lo_sel = IdxW'(i);
                if (IdxW'(i) >= ptr_i) begin
                    hi_sel   = IdxW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        any_o    = |pending_i;
        sel_o    = hi_found ? hi_sel : lo_sel;
        onehot_o = any_o ? (N'(1) << sel_o) : '0;
    end

endmodule

// File: rtl/req_dispatcher.sv
// Consumer of the request queue head: grants each set bit of the latched entry
// in round-robin order over valid/ready, then pops the entry.
// Optional build macro REQ_DISPATCH_ABORT_EN: an all-zero head during GRANT
// abandons the entry without a pop.
module req_dispatcher
    import req_dispatch_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    head_req,
    input  logic            head_empty,
    output logic            pop,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_valid,
    input  logic            gnt_ready,
    output logic            busy
);

    dispatch_state_e state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [IdxW-1:0] ptr_q, ptr_d;

    logic [IdxW-1:0] sel_cur, sel_nxt;
    logic [N-1:0]    oh_cur, oh_nxt;
    logic            any_cur, any_nxt;
    logic            abort;
    logic            grant_nxt;

    // Picker on the current registers decides what is being granted now.
    rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick_cur (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .sel_o     (sel_cur),
        .onehot_o  (oh_cur),
        .any_o     (any_cur)
    );

    // Picker on the next-state values lets the grant outputs be registered.
    rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick_nxt (
        .pending_i (pending_d),
        .ptr_i     (ptr_d),
        .sel_o     (sel_nxt),
        .onehot_o  (oh_nxt),
        .any_o     (any_nxt)
    );

`ifdef REQ_DISPATCH_ABORT_EN
    assign abort = (head_req == '0);
`else
    assign abort = 1'b0;
`endif

    // Next-state: latch entry in IDLE, retire one bit per accepted grant.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ptr_d     = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (!head_empty && (|head_req)) begin
                    pending_d = head_req;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (abort) begin
                    // Abort wins over a same-cycle acceptance; ptr stays put.
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (gnt_ready && any_cur) begin
                    pending_d = pending_q & ~oh_cur;
                    ptr_d     = (sel_cur == IdxW'(N - 1)) ? '0 : sel_cur + IdxW'(1);
                    if ((pending_q & ~oh_cur) == '0) begin
                        state_d = POP;
                    end
                end
            end
            POP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    assign grant_nxt = (state_d == GRANT) && any_nxt;

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            pop       <= 1'b0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            pop       <= (state_d == POP);
            gnt_valid <= grant_nxt;
            gnt       <= grant_nxt ? oh_nxt : '0;
            gnt_idx   <= grant_nxt ? sel_nxt : '0;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_req_dispatcher.sv
// Self-checking bench for req_dispatcher with a transaction-level grant model.
module tb_req_dispatcher;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  head_req;
    logic          head_empty;
    logic          pop;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          gnt_ready;
    logic          busy;

    int n_cmp   = 0;
    int n_err   = 0;
    int pop_cnt = 0;
    int m_ptr   = 0;

    req_dispatcher #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .head_req   (head_req),
        .head_empty (head_empty),
        .pop        (pop),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pop === 1'b1) pop_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first set bit scanning ptr, ptr+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Serve one entry; stall_first holds ready low on the first grant.
    task automatic run_entry(input logic [N-1:0] req, input int stall_first,
                             input bit rnd_ready, input bit zero_junk, input string name);
        int exp_q[$];
        logic [N-1:0] p;
        int ptr;
        int s;
        int pops0;
        int waits;
        bit accepted;
        p     = req;
        ptr   = m_ptr;
        while (p != '0) begin
            s = pick(p, ptr);
            exp_q.push_back(s);
            p[s] = 1'b0;
            ptr  = (s + 1) % N;
        end
        pops0      = pop_cnt;
        head_req   = req;
        head_empty = 1'b0;
        gnt_ready  = 1'b0;
        tick;
        head_empty = 1'($urandom_range(0, 1));
        head_req   = zero_junk ? '0 : N'($urandom_range(1, 15));
        foreach (exp_q[k]) begin
            waits    = 0;
            accepted = 1'b0;
            while (!accepted) begin
                n_cmp++;
                if ({gnt_valid, gnt, gnt_idx, pop, busy} !==
                    {1'b1, N'(1 << exp_q[k]), IW'(exp_q[k]), 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL %s grant%0d: got valid=%b gnt=%b idx=%0d pop=%b busy=%b, want gnt=%b idx=%0d",
                             name, k, gnt_valid, gnt, gnt_idx, pop, busy,
                             N'(1 << exp_q[k]), exp_q[k]);
                end
                if (k == 0 && waits < stall_first) gnt_ready = 1'b0;
                else if (rnd_ready && waits < 6) gnt_ready = 1'($urandom_range(0, 1));
                else gnt_ready = 1'b1;
                accepted = gnt_ready;
                waits++;
                tick;
            end
        end
        gnt_ready  = 1'b0;
        head_empty = 1'b1;
        m_ptr      = (exp_q[$] + 1) % N;
        n_cmp++;
        if ({pop, gnt_valid, gnt, busy} !== {1'b1, 1'b0, N'(0), 1'b1}) begin
            n_err++;
            $display("FAIL %s pop_cycle: got pop=%b valid=%b gnt=%b busy=%b, want 1 0 0000 1",
                     name, pop, gnt_valid, gnt, busy);
        end
        tick;
        n_cmp++;
        if ({pop, gnt_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after_pop: got pop=%b valid=%b busy=%b, want 000",
                     name, pop, gnt_valid, busy);
        end
        n_cmp++;
        if (pop_cnt - pops0 !== 1) begin
            n_err++;
            $display("FAIL %s pop_count: got %0d, want 1", name, pop_cnt - pops0);
        end
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        head_empty = 1'b1;
        gnt_ready  = 1'b0;
        tick;
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        head_req   = 4'b1111;
        head_empty = 1'b0;
        gnt_ready  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            n_cmp++;
            if ({pop, gnt, gnt_idx, gnt_valid, busy} !== '0) begin
                n_err++;
                $display("FAIL reset_hold%0d: got pop=%b gnt=%b idx=%0d valid=%b busy=%b, want all 0",
                         c, pop, gnt, gnt_idx, gnt_valid, busy);
            end
        end
        rst        = 1'b0;
        head_empty = 1'b1;
        tick;
        n_cmp++;
        if ({pop, gnt, gnt_idx, gnt_valid, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got pop=%b gnt=%b idx=%0d valid=%b busy=%b, want all 0",
                     pop, gnt, gnt_idx, gnt_valid, busy);
        end
        m_ptr = 0;
    endtask

    task automatic test_full_entry;
        run_entry(4'b1011, 0, 1'b0, 1'b0, "full_1011");
        n_cmp++;
        if (m_ptr !== 0) begin
            n_err++;
            $display("FAIL full_ptr: model ptr %0d, want 0", m_ptr);
        end
    endtask

    task automatic test_carry;
        int p0;
        p0 = pop_cnt;
        run_entry(4'b0010, 0, 1'b0, 1'b0, "carry_0010");
        run_entry(4'b0111, 0, 1'b0, 1'b0, "carry_0111");
        n_cmp++;
        if (pop_cnt - p0 !== 2) begin
            n_err++;
            $display("FAIL carry_pops: got %0d, want 2", pop_cnt - p0);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        run_entry(4'b0101, 3, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_empty;
        head_empty = 1'b1;
        head_req   = 4'b0001;
        gnt_ready  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_cmp++;
            if ({busy, gnt_valid, gnt, pop} !== '0) begin
                n_err++;
                $display("FAIL empty%0d: got busy=%b valid=%b gnt=%b pop=%b, want all 0",
                         c, busy, gnt_valid, gnt, pop);
            end
        end
        gnt_ready = 1'b0;
    endtask

    task automatic test_rst_mid;
        int p0;
        int s;
        p0         = pop_cnt;
        s          = pick(4'b1111, m_ptr);
        head_req   = 4'b1111;
        head_empty = 1'b0;
        tick;
        head_empty = 1'b1;
        n_cmp++;
        if ({gnt_valid, gnt_idx} !== {1'b1, IW'(s)}) begin
            n_err++;
            $display("FAIL rstmid_grant: got valid=%b idx=%0d, want 1 %0d", gnt_valid, gnt_idx, s);
        end
        gnt_ready = 1'b1;
        tick;
        gnt_ready = 1'b0;
        rst       = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++;
        if ({pop, gnt, gnt_valid, busy} !== '0) begin
            n_err++;
            $display("FAIL rstmid_state: got pop=%b gnt=%b valid=%b busy=%b, want all 0",
                     pop, gnt, gnt_valid, busy);
        end
        tick;
        n_cmp++;
        if (pop_cnt !== p0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_nopop: got pops=%0d busy=%b, want %0d 0", pop_cnt - p0, busy, 0);
        end
        m_ptr = 0;
        run_entry(4'b1111, 0, 1'b0, 1'b0, "rstmid_ptr0");
    endtask

    task automatic test_abort;
`ifdef REQ_DISPATCH_ABORT_EN
        int p0;
        p0 = pop_cnt;
        for (int r = 0; r < 2; r++) begin
            head_req   = 4'b0110;
            head_empty = 1'b0;
            gnt_ready  = 1'b0;
            tick;
            head_empty = 1'b1;
            head_req   = '0;
            gnt_ready  = 1'(r);
            tick;
            gnt_ready = 1'b0;
            n_cmp++;
            if ({busy, gnt_valid, pop} !== 3'b000) begin
                n_err++;
                $display("FAIL abort%0d: got busy=%b valid=%b pop=%b, want 000",
                         r, busy, gnt_valid, pop);
            end
            tick;
        end
        n_cmp++;
        if (pop_cnt !== p0) begin
            n_err++;
            $display("FAIL abort_pops: got %0d, want 0", pop_cnt - p0);
        end
        run_entry(4'b1111, 0, 1'b0, 1'b0, "abort_ptr_kept");
`else
        run_entry(4'b0110, 1, 1'b0, 1'b1, "no_abort_zero_head");
`endif
    endtask

    task automatic test_random;
        int gap;
        for (int e = 0; e < 40; e++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                head_empty = 1'($urandom_range(0, 1));
                head_req   = head_empty ? N'($urandom_range(0, 15)) : '0;
                tick;
                n_cmp++;
                if ({busy, gnt_valid, pop} !== 3'b000) begin
                    n_err++;
                    $display("FAIL rand_idle%0d: got busy=%b valid=%b pop=%b, want 000",
                             e, busy, gnt_valid, pop);
                end
            end
            run_entry(N'($urandom_range(1, 15)), 0, 1'b1, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset;
        test_full_entry;
        test_carry;
        test_backpressure;
        test_empty;
        test_rst_mid;
        test_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
